level_meter: RTL

LEVEL_METER -- requirements
Module: level_meter

---
 rtl/level_meter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/level_meter.sv
// level_meter: |sum_in >>> AVG_SHIFT| saturated to NUM_BITS_OUT bits,
// plus a peak tracker and a sticky clip flag.
//
// Build option: define LEVEL_METER_PEAK_HOLD_EN to enable the peak
// hold/decay state machine. Without it, peak_out mirrors level_out.
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   sum_en    : sum_in valid this cycle
//   sum_in    : signed running sum from the averaging stage
//   clip_clr  : clears the sticky clip flag (a new saturation wins)
//   level_out : unsigned saturated magnitude of the average
//   level_en  : one-cycle pulse, level_out updated (2 cycles after sum_en)
//   peak_out  : held/decaying peak (or level_out when hold disabled)
//   clip      : sticky saturation flag
module level_meter #(
  parameter int NUM_BITS_IN  = 64,
  parameter int AVG_SHIFT    = 6,
  parameter int NUM_BITS_OUT = 16,
  parameter int HOLD_CYCLES  = 4800,
  parameter int DECAY_SHIFT  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sum_en,
  input  logic [NUM_BITS_IN-1:0]  sum_in,
  input  logic                    clip_clr,
  output logic [NUM_BITS_OUT-1:0] level_out,
  output logic                    level_en,
  output logic [NUM_BITS_OUT-1:0] peak_out,
  output logic                    clip
);

  // The average keeps AW bits; its magnitude also fits in AW bits
  // as an unsigned value, including 2^(AW-1) for the most negative.
  localparam int AW = NUM_BITS_IN - AVG_SHIFT;
  localparam int EW = AW + NUM_BITS_OUT;

  logic [AW-1:0]           avg;
  logic [AW-1:0]           mag_d;
  logic [AW-1:0]           mag_q;
  logic                    v1;
  logic [EW-1:0]           mag_ext;
  logic                    sat_d;
  logic                    sat_q;
  logic [NUM_BITS_OUT-1:0] lvl_d;
  logic                    unused_low;

  // Arithmetic right shift == dropping the low bits of the sum.
  assign avg        = sum_in[NUM_BITS_IN-1:AVG_SHIFT];
  assign unused_low = ^sum_in[AVG_SHIFT-1:0];

  assign mag_d = avg[AW-1] ? (~avg + AW'(1)) : avg;

  assign mag_ext = {{NUM_BITS_OUT{1'b0}}, mag_q};
  assign sat_d   = |mag_ext[EW-1:NUM_BITS_OUT];
  assign lvl_d   = sat_d ? '1 : mag_ext[NUM_BITS_OUT-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      mag_q     <= '0;
      level_en  <= 1'b0;
      level_out <= '0;
      sat_q     <= 1'b0;
      clip      <= 1'b0;
    end else begin
      v1       <= sum_en;
      level_en <= v1;
      sat_q    <= v1 & sat_d;
      if (sum_en) begin
        mag_q <= mag_d;
      end
      if (v1) begin
        level_out <= lvl_d;
      end
      // A saturation seen this cycle outranks a clear request.
      if (sat_q) begin
        clip <= 1'b1;
      end else if (clip_clr) begin
        clip <= 1'b0;
      end
    end
  end

`ifdef LEVEL_METER_PEAK_HOLD_EN

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DECAY
  } state_t;

  state_t                  state;
  state_t                  state_d;
  logic [CW-1:0]           cnt;
  logic [CW-1:0]           cnt_d;
  logic [NUM_BITS_OUT-1:0] peak;
  logic [NUM_BITS_OUT-1:0] peak_d;
  logic [NUM_BITS_OUT-1:0] dec;
  logic [NUM_BITS_OUT-1:0] drop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      peak  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      peak  <= peak_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    peak_d  = peak;
    dec     = peak >> DECAY_SHIFT;
    if (dec == '0) begin
      dec = NUM_BITS_OUT'(1);
    end
    // Peak is nonzero whenever DECAY is active, so no underflow.
    drop = peak - dec;
    if (level_en && (level_out > peak)) begin
      peak_d  = level_out;
      state_d = HOLD;
      cnt_d   = CW'(HOLD_CYCLES - 1);
    end else begin
      unique case (state)
        IDLE: begin
          peak_d = '0;
        end
        HOLD: begin
          if (cnt == '0) begin
            state_d = DECAY;
          end else begin
            cnt_d = cnt - CW'(1);
          end
        end
        DECAY: begin
          if (level_en) begin
            peak_d = (drop < level_out) ? level_out : drop;
            if (peak_d == '0) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          peak_d  = '0;
        end
      endcase
    end
  end

  assign peak_out = peak;

`else

  localparam int unused_cfg = HOLD_CYCLES + DECAY_SHIFT;

  assign peak_out = level_out;

`endif

endmodule
